// File: rtl/inst_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit instruction
// words and writes them to instruction memory, holding the core meanwhile.
module inst_loader #(
  parameter int          DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start_i,
  input  logic [15:0] load_len_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word_lo;
  logic        r_byte_ready;
  logic        r_mem_we;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_cpu_hold;
  logic        r_load_busy;
  logic        r_load_done;
  logic        r_load_err;

  logic        w_accept;
  logic        w_len_ok;
  logic        w_last_word;

  // r_byte_ready is only ever set in RECV, so it doubles as the state qualifier.
  assign w_accept    = byte_valid_i & r_byte_ready;
  assign w_len_ok    = (load_len_i != 16'd0) && (int'(load_len_i) <= DEPTH);
  assign w_last_word = (r_word_cnt == r_len - 16'd1);

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_word_lo    <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start_i) begin
            if (w_len_ok) begin
              r_len        <= load_len_i;
              r_word_cnt   <= '0;
              r_byte_cnt   <= '0;
              r_load_err   <= 1'b0;
              r_byte_ready <= 1'b1;
              r_cpu_hold   <= 1'b1;
              r_load_busy  <= 1'b1;
              r_state      <= S_RECV;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Fourth byte goes straight to the top lane of the output word.
              r_mem_wdata  <= {byte_data_i, r_word_lo};
              r_mem_waddr  <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
              r_mem_we     <= 1'b1;
              r_byte_ready <= 1'b0;
              r_state      <= S_WRITE;
            end else begin
              r_word_lo[8*r_byte_cnt +: 8] <= byte_data_i;
            end
          end
        end

        S_WRITE: begin
          r_mem_we   <= 1'b0;
          r_word_cnt <= r_word_cnt + 16'd1;
          if (w_last_word) begin
            r_load_done <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_byte_ready <= 1'b1;
            r_state      <= S_RECV;
          end
        end

        S_DONE: begin
          r_load_done <= 1'b0;
          r_cpu_hold  <= 1'b0;
          r_load_busy <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = r_byte_ready;
  assign mem_we_o     = r_mem_we;
  assign mem_waddr_o  = r_mem_waddr;
  assign mem_wdata_o  = r_mem_wdata;
  assign cpu_hold_o   = r_cpu_hold;
  assign load_busy_o  = r_load_busy;
  assign load_done_o  = r_load_done;
  assign load_err_o   = r_load_err;

endmodule
